// File: rtl/syst_skew_feeder.sv
// syst_skew_feeder: front end for a weight-stationary systolic column array.
// Accepts one N_ROWS-lane vector per handshake and launches it diagonally:
// lane i sits behind i+1 registers, so row i sees the sample one cycle after
// row i-1, lining up with the one-register-per-row psumm path of the array.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          global advance; low stalls the feeder and the array
//   in_data/valid   input vector (lane i at [i*X_WIDTH +: X_WIDTH])
//   in_ready        = enable
//   x_o/valid_x_o   skewed samples and per-row valids into the array
//   psumm_seed_o    zero seed for column tops
//   valid_psumm_o   seed valid, same register as valid_x_o[0]
//   array_en_o      = enable
//   busy_o          a valid sample is still in some skew stage
//   vec_cnt_o       accepted vectors since reset, wraps

// One lane of the skew: DEPTH stages of {valid, data}.
// The data of an invalid stage is forced to 0 at entry, so bubbles never
// carry stale samples downstream.
module syst_skew_lane #(
  parameter int DEPTH   = 1,
  parameter int X_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               vin,
  input  logic [X_WIDTH-1:0] din,
  output logic               vout,
  output logic [X_WIDTH-1:0] dout,
  output logic               busy
);
  localparam int STAGES = DEPTH - 1;

  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][X_WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (en) begin
      vld_pipe[0] <= vin;
      dat_pipe[0] <= vin ? din : '0;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign vout = vld_pipe[STAGES];
  assign dout = dat_pipe[STAGES];
  assign busy = |vld_pipe;
endmodule

module syst_skew_feeder #(
  parameter int N_ROWS    = 4,
  parameter int X_WIDTH   = 16,
  parameter int SI_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [N_ROWS*X_WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N_ROWS*X_WIDTH-1:0] x_o,
  output logic [N_ROWS-1:0]         valid_x_o,
  output logic [SI_WIDTH-1:0]       psumm_seed_o,
  output logic                      valid_psumm_o,
  output logic                      array_en_o,
  output logic                      busy_o,
  output logic [CNT_WIDTH-1:0]      vec_cnt_o
);
  logic                           xfer;
  logic [N_ROWS-1:0][X_WIDTH-1:0] x_lane;
  logic [N_ROWS-1:0]              lane_busy;
  logic [CNT_WIDTH-1:0]           vec_cnt;

  // No internal backpressure: the feeder and the array stall together.
  assign in_ready   = enable;
  assign array_en_o = enable;
  assign xfer       = in_valid & in_ready;

  for (genvar g = 0; g < N_ROWS; g++) begin : g_lane
    syst_skew_lane #(
      .DEPTH   (g + 1),
      .X_WIDTH (X_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (enable),
      .vin  (xfer),
      .din  (in_data[g*X_WIDTH +: X_WIDTH]),
      .vout (valid_x_o[g]),
      .dout (x_lane[g]),
      .busy (lane_busy[g])
    );
  end

  assign x_o           = x_lane;
  assign busy_o        = |lane_busy;
  assign psumm_seed_o  = '0;
  // Row 0's valid register doubles as the seed valid: no extra delay.
  assign valid_psumm_o = valid_x_o[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       vec_cnt <= '0;
    else if (xfer) vec_cnt <= vec_cnt + CNT_WIDTH'(1);
  end

  assign vec_cnt_o = vec_cnt;
endmodule

// File: doc/syst_skew_feeder.md
Name: syst_skew_feeder

Overview:
- Front-end driver for a weight-stationary systolic column array built from syst_node cells.
- Accepts one N-element input vector per handshake and launches it into the array's x inputs with a diagonal skew. Row i is delayed i cycles more than row 0, matching the one-register-per-row psumm path.
- Generates the zero partial-sum seed and its valid for the top of every column, and gates the array-wide enable.

Parameters:
- N_ROWS, 4, number of array rows (x lanes); must be >= 1.
- X_WIDTH, 16, signed sample width per lane.
- SI_WIDTH, 32, width of the psumm seed driven into column tops.
- CNT_WIDTH, 16, width of the accepted-vector counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  global advance; low = whole feeder and array stall.
- in_data  in  N_ROWS*X_WIDTH  input vector; lane i at bits [i*X_WIDTH +: X_WIDTH].
- in_valid  in  1  in_data valid.
- in_ready  out  1  feeder can accept in_data this cycle.
- x_o  out  N_ROWS*X_WIDTH  skewed samples to row i x_i, same lane packing.
- valid_x_o  out  N_ROWS  per-row valid to row i valid_x_i.
- psumm_seed_o  out  SI_WIDTH  constant zero seed for column-top psumm_i.
- valid_psumm_o  out  1  seed valid for column tops, aligned with row 0.
- array_en_o  out  1  enable to all syst_node cells.
- busy_o  out  1  at least one valid sample still inside the skew lines.
- vec_cnt_o  out  CNT_WIDTH  number of vectors accepted since reset.

Behaviour:
- Handshake:
  - in_ready = enable, combinational; there is no internal backpressure beyond enable.
  - A transfer occurs when in_valid & in_ready at a rising edge.
- Skew lines:
  - Lane i is a shift register of depth i+1 carrying {valid, data}.
  - Stage 0 of every lane loads in_data lane i and valid = (in_valid & in_ready) on each enabled edge.
  - Deeper stages shift by one on each enabled edge.
  - When enable = 0, every stage holds; nothing is lost or duplicated.
- Outputs:
  - x_o lane i and valid_x_o[i] come from the last stage of lane i.
  - Latency from transfer to row i output is i+1 enabled cycles.
- Bubbles:
  - A cycle with in_valid = 0 and enable = 1 shifts in valid = 0 and data = 0.
  - Data of invalid stages is always 0, so no stale samples appear downstream.
- Seed:
  - psumm_seed_o is hard-wired 0.
  - valid_psumm_o is identical to valid_x_o[0] (same register, not a copy with extra delay).
- array_en_o = enable, combinational, so the feeder and the array stall in the same cycle.
- busy_o = OR of all valid bits in all stages, combinational from registers.
  - After the last transfer, busy_o falls after N_ROWS enabled cycles.
- vec_cnt_o increments by 1 on each transfer and wraps modulo 2^CNT_WIDTH with no saturation flag.
- Reset (async assert, sampled release):
  - All stage valids and data go to 0, and vec_cnt_o goes to 0.
  - Therefore valid_x_o = 0, x_o = 0, valid_psumm_o = 0, busy_o = 0.
  - in_ready and array_en_o follow enable combinationally even during reset; transfers during reset are ignored.
  - Reset mid-stream discards every in-flight sample.
- Simultaneous events: a transfer while enable drops is impossible because in_ready = enable.
- N_ROWS = 1 degenerates to a single register stage with latency 1.
- Arithmetic: no arithmetic on data; samples pass bit-exact, sign preserved.

Test Plan:
- Reset then idle, enable = 1, in_valid = 0 for 10 cycles -> all outputs 0, busy_o = 0, vec_cnt_o = 0.
- N_ROWS = 4, single transfer of lanes {4,-3,2,1} (lane0 = 1) -> row0 shows 1 at cycle +1, row1 shows 2 at +2, row2 shows -3 at +3, row3 shows 4 at +4. Each valid is high exactly one cycle. valid_psumm_o is high at +1 with seed 0. busy_o falls at +5. vec_cnt_o = 1.
- Back-to-back transfers of vectors A, B, C with enable = 1 -> each row outputs A, B, C on consecutive cycles, offset i+1. vec_cnt_o = 3.
- Transfer A, then hold enable = 0 for 3 cycles mid-skew -> in_ready = 0 and array_en_o = 0 during the stall. All outputs are frozen. The remaining rows resume in order after enable returns, with the total latency extended by 3.
- Assert rst while A and B are in flight -> outputs 0 immediately (asynchronous). No stale valids after release. vec_cnt_o = 0.
- Preload vec_cnt_o to 2^CNT_WIDTH-1 via transfers (CNT_WIDTH = 4, 15 transfers), then one more -> vec_cnt_o wraps to 0.
